// File: rtl/mem_wb_lsu.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_lsu
// Purpose  : Memory-access / writeback stage. Issues sized loads and stores
//            over a req/ack data bus, aligns and extends load data, stalls
//            the pipeline while an access is outstanding and registers the
//            register-file write port (we/waddr/wdata).
// Revision : 1.0 - initial release
// ============================================================================
module mem_wb_lsu #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_i,
  input  logic [3:0]    mem_op_i,
  input  logic [DW-1:0] mem_addr_i,
  input  logic [DW-1:0] store_data_i,
  input  logic [DW-1:0] alu_result_i,
  input  logic [AW-1:0] wd_i,
  input  logic          wreg_i,
  output logic          stall_o,
  output logic          dbus_req_o,
  output logic          dbus_we_o,
  output logic [DW-1:0] dbus_addr_o,
  output logic [3:0]    dbus_be_o,
  output logic [DW-1:0] dbus_wdata_o,
  input  logic          dbus_ack_i,
  input  logic [DW-1:0] dbus_rdata_i,
  output logic          wb_we_o,
  output logic [AW-1:0] wb_waddr_o,
  output logic [DW-1:0] wb_wdata_o,
  output logic          misalign_o
);

  localparam logic [3:0] c_OP_LB  = 4'd1;
  localparam logic [3:0] c_OP_LBU = 4'd2;
  localparam logic [3:0] c_OP_LH  = 4'd3;
  localparam logic [3:0] c_OP_LHU = 4'd4;
  localparam logic [3:0] c_OP_LW  = 4'd5;
  localparam logic [3:0] c_OP_SB  = 4'd6;
  localparam logic [3:0] c_OP_SH  = 4'd7;
  localparam logic [3:0] c_OP_SW  = 4'd8;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t          r_state;
  logic [3:0]      r_op;
  logic [1:0]      r_off;
  logic [AW-1:0]   r_wd;
  logic            r_wreg;

  logic            w_is_load;
  logic            w_is_store;
  logic            w_is_half;
  logic            w_is_word;
  logic            w_is_byte;
  logic            w_mem;
  logic            w_misalign;
  logic [3:0]      w_be;
  logic [DW-1:0]   w_wdata;
  logic            w_r_is_load;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [DW-1:0]   w_load_data;
  logic            w_stall;

  // Decode the incoming operation: size class, alignment and lane steering.
  always_comb begin
    w_is_load  = (mem_op_i >= c_OP_LB) && (mem_op_i <= c_OP_LW);
    w_is_store = (mem_op_i >= c_OP_SB) && (mem_op_i <= c_OP_SW);
    w_is_byte  = (mem_op_i == c_OP_LB) || (mem_op_i == c_OP_LBU) || (mem_op_i == c_OP_SB);
    w_is_half  = (mem_op_i == c_OP_LH) || (mem_op_i == c_OP_LHU) || (mem_op_i == c_OP_SH);
    w_is_word  = (mem_op_i == c_OP_LW) || (mem_op_i == c_OP_SW);
    w_mem      = valid_i && (w_is_load || w_is_store);
    w_misalign = (w_is_half && mem_addr_i[0]) || (w_is_word && (mem_addr_i[1:0] != 2'b00));
    w_be       = 4'b1111;
    w_wdata    = store_data_i;
    if (w_is_byte) begin
      w_be    = 4'b0001 << mem_addr_i[1:0];
      w_wdata = {(DW/8){store_data_i[7:0]}};
    end else if (w_is_half) begin
      w_be    = mem_addr_i[1] ? 4'b1100 : 4'b0011;
      w_wdata = {(DW/16){store_data_i[15:0]}};
    end
  end

  // Pick the addressed byte/half out of the read word and extend it.
  always_comb begin
    w_r_is_load = (r_op >= c_OP_LB) && (r_op <= c_OP_LW);
    w_byte      = dbus_rdata_i[{r_off, 3'b000} +: 8];
    w_half      = dbus_rdata_i[{r_off[1], 4'b0000} +: 16];
    case (r_op)
      c_OP_LB:  w_load_data = {{(DW-8){w_byte[7]}}, w_byte};
      c_OP_LBU: w_load_data = {{(DW-8){1'b0}}, w_byte};
      c_OP_LH:  w_load_data = {{(DW-16){w_half[15]}}, w_half};
      c_OP_LHU: w_load_data = {{(DW-16){1'b0}}, w_half};
      default:  w_load_data = dbus_rdata_i;
    endcase
  end

  // Hold upstream while an aligned access is being accepted or is still waiting for ack.
  always_comb begin
    w_stall = (r_state == S_IDLE) ? (w_mem && !w_misalign) : !dbus_ack_i;
    stall_o = rst && w_stall;
  end

  // Control FSM with registered bus and writeback outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_op         <= '0;
      r_off        <= '0;
      r_wd         <= '0;
      r_wreg       <= 1'b0;
      dbus_req_o   <= 1'b0;
      dbus_we_o    <= 1'b0;
      dbus_addr_o  <= '0;
      dbus_be_o    <= '0;
      dbus_wdata_o <= '0;
      wb_we_o      <= 1'b0;
      wb_waddr_o   <= '0;
      wb_wdata_o   <= '0;
      misalign_o   <= 1'b0;
    end else begin
      misalign_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_mem && w_misalign) begin
            wb_we_o    <= 1'b0;
            misalign_o <= 1'b1;
          end else if (w_mem) begin
            r_op         <= mem_op_i;
            r_off        <= mem_addr_i[1:0];
            r_wd         <= wd_i;
            r_wreg       <= wreg_i;
            dbus_req_o   <= 1'b1;
            dbus_we_o    <= w_is_store;
            dbus_addr_o  <= {mem_addr_i[DW-1:2], 2'b00};
            dbus_be_o    <= w_be;
            dbus_wdata_o <= w_wdata;
            wb_we_o      <= 1'b0;
            r_state      <= S_BUSY;
          end else begin
            // Register 0 is never written so the regfile bypass cannot forward to it.
            wb_we_o    <= wreg_i && valid_i && (wd_i != '0);
            wb_waddr_o <= wd_i;
            wb_wdata_o <= alu_result_i;
          end
        end
        S_BUSY: begin
          if (dbus_ack_i) begin
            dbus_req_o <= 1'b0;
            r_state    <= S_IDLE;
            wb_waddr_o <= r_wd;
            wb_wdata_o <= w_load_data;
            wb_we_o    <= w_r_is_load && r_wreg && (r_wd != '0);
          end else begin
            wb_we_o <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
